// File: rtl/serial_borrow_subtractor_if.sv
// rtl/serial_borrow_subtractor_if.sv - operand/result handshake bundle for serial_borrow_subtractor
// Ports (interface members):
//   in_valid / in_ready          - operand handshake
//   X, Y, B0                     - minuend, subtrahend, borrow in
//   out_valid / out_ready        - result handshake
//   difference, borrow_out, zero - result fields
// Modports: master drives operands and consumes results, slave is the subtractor.
interface serial_borrow_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             B0;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] difference;
   logic             borrow_out;
   logic             zero;

   modport master (
      output in_valid, X, Y, B0, out_ready,
      input  in_ready, out_valid, difference, borrow_out, zero
   );

   modport slave (
      input  in_valid, X, Y, B0, out_ready,
      output in_ready, out_valid, difference, borrow_out, zero
   );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - bit-serial X - Y - B0 subtractor, LSB first, behind valid/ready
// Optional macro: SERIAL_SUB_SATURATE_EN clamps an underflowing result to zero (borrow_out stays 1).
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - serial_borrow_subtractor_if.slave
//         in_valid/in_ready/X/Y/B0 operand request, accepted only in IDLE
//         out_valid/out_ready/difference/borrow_out/zero result, held until taken
module serial_borrow_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                       clk,
   input logic                       rst,
   serial_borrow_subtractor_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] x_sh;
   logic [WIDTH-1:0] y_sh;
   logic [WIDTH-1:0] res_sh;
   logic             borrow;
   logic [CNT_W-1:0] cnt;

   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] difference_r;
   logic             borrow_out_r;
   logic             zero_r;

   // One full-subtractor cell; operand bits are always taken from position 0
   // because both operand registers shift right once per RUN cycle.
   logic             x_bit;
   logic             y_bit;
   logic             d_bit;
   logic             b_next;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] final_diff;
   logic             final_zero;

   assign x_bit  = x_sh[0];
   assign y_bit  = y_sh[0];
   assign d_bit  = x_bit ^ y_bit ^ borrow;
   assign b_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow);

   // Result enters at the MSB; after WIDTH shifts the first bit lands in bit 0.
   assign res_next = {d_bit, res_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_SATURATE_EN
   assign final_diff = b_next ? '0 : res_next;
`else
   assign final_diff = res_next;
`endif

   assign final_zero = (final_diff == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         x_sh         <= '0;
         y_sh         <= '0;
         res_sh       <= '0;
         borrow       <= 1'b0;
         cnt          <= '0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         difference_r <= '0;
         borrow_out_r <= 1'b0;
         zero_r       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_sh       <= bus.X;
                  y_sh       <= bus.Y;
                  borrow     <= bus.B0;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end

            RUN: begin
               x_sh   <= x_sh >> 1;
               y_sh   <= y_sh >> 1;
               res_sh <= res_next;
               borrow <= b_next;
               if (cnt == CNT_LAST) begin
                  // Result registers are only written here, so a reset
                  // mid-RUN can never expose a partial result.
                  cnt          <= '0;
                  difference_r <= final_diff;
                  borrow_out_r <= b_next;
                  zero_r       <= final_zero;
                  out_valid_r  <= 1'b1;
                  state        <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.difference = difference_r;
   assign bus.borrow_out = borrow_out_r;
   assign bus.zero       = zero_r;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb/tb_serial_borrow_subtractor.sv - randomized self-checking bench for serial_borrow_subtractor
// Ports: none (top-level bench); drives the DUT through serial_borrow_subtractor_if.
// Honours SERIAL_SUB_SATURATE_EN the same way as the design.
module tb_serial_borrow_subtractor;

   localparam int W   = 8;
   localparam int MOD = 1 << W;
`ifdef SERIAL_SUB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      int d;
      int bo;
      int z;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   serial_borrow_subtractor_if #(.WIDTH(W)) bus ();

   serial_borrow_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: what the result must be.
   function automatic res_t ref_sub(input int x, input int y, input int b);
      res_t r;
      int   raw;
      raw  = x - y - b;
      r.bo = (raw < 0) ? 1 : 0;
      r.d  = ((raw % MOD) + MOD) % MOD;
      if (SAT && r.bo == 1) r.d = 0;
      r.z  = (r.d == 0) ? 1 : 0;
      return r;
   endfunction

   // Transaction-level model: busy for W cycles after an accept, then holds
   // the result until the consumer takes it.
   int   m_ready = 1;
   int   m_valid = 0;
   int   m_left  = 0;
   res_t m_res   = '0;
   res_t p_res   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready <= 1;
         m_valid <= 0;
         m_left  <= 0;
         m_res   <= '0;
      end else if (m_ready == 1) begin
         if (bus.in_valid) begin
            p_res   <= ref_sub(int'(bus.X), int'(bus.Y), int'(bus.B0));
            m_ready <= 0;
            m_left  <= W;
         end
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_valid <= 1;
            m_res   <= p_res;
         end
      end else if (m_valid == 1 && bus.out_ready) begin
         m_valid <= 0;
         m_ready <= 1;
      end
   end

   always @(negedge clk) begin
      check("cyc_in_ready",   bus.in_ready,   m_ready);
      check("cyc_out_valid",  bus.out_valid,  m_valid);
      check("cyc_difference", bus.difference, m_res.d);
      check("cyc_borrow_out", bus.borrow_out, m_res.bo);
      check("cyc_zero",       bus.zero,       m_res.z);
   end

   task automatic run_txn(input string name, input int x, input int y, input int b,
                          input int ed, input int ebo, input int ez,
                          input int bp, input bit noise);
      int       cyc;
      logic [W-1:0] xv;
      logic [W-1:0] yv;
      @(negedge clk);
      cyc = 0;
      while (m_ready == 0 && cyc < 4 * W) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_ready"}, bus.in_ready, 1);
      xv = x[W-1:0];
      yv = y[W-1:0];
      bus.X        = xv;
      bus.Y        = yv;
      bus.B0       = b[0];
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      // Operand changes after the accept edge must not matter.
      bus.X  = W'($urandom);
      bus.Y  = W'($urandom);
      bus.B0 = 1'($urandom);
      cyc = 0;
      while (!bus.out_valid && cyc < 4 * W) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_latency"},    cyc,            W);
      check({name, "_difference"}, bus.difference, ed);
      check({name, "_borrow_out"}, bus.borrow_out, ebo);
      check({name, "_zero"},       bus.zero,       ez);
      for (int i = 0; i < bp; i++) begin
         if (noise && i == 1) begin
            bus.X        = 8'd9;
            bus.Y        = 8'd9;
            bus.B0       = 1'b0;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         check({name, "_hold_diff"},     bus.difference, ed);
         check({name, "_hold_in_ready"}, bus.in_ready,   0);
         check({name, "_hold_valid"},    bus.out_valid,  1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, "_ready_after"}, bus.in_ready,  1);
      check({name, "_valid_after"}, bus.out_valid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      int   xc;
      bus.in_valid  = 1'b0;
      bus.X         = '0;
      bus.Y         = '0;
      bus.B0        = 1'b0;
      bus.out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_in_ready",   bus.in_ready,   1);
      check("reset_out_valid",  bus.out_valid,  0);
      check("reset_difference", bus.difference, 0);
      check("reset_borrow_out", bus.borrow_out, 0);
      check("reset_zero",       bus.zero,       0);
      #2 rst = 1'b0;

      run_txn("basic",     3,   1,   0, 2, 0, 0, 0, 1'b0);
      run_txn("underflow", 0,   1,   0, SAT ? 0 : 255, 1, SAT ? 1 : 0, 0, 1'b0);
      run_txn("borrow_in", 128, 127, 1, 0, 0, 1, 0, 1'b0);
      run_txn("equal",     77,  77,  0, 0, 0, 1, 0, 1'b0);
      run_txn("max_borrow", 0, 255, 1, 0, 1, 1, 0, 1'b0);
      run_txn("backpress", 16,  8,   0, 8, 0, 0, 5, 1'b1);

      // Abort four cycles into RUN.
      @(negedge clk);
      bus.X        = 8'd50;
      bus.Y        = 8'd7;
      bus.B0       = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrun_in_ready",   bus.in_ready,   1);
      check("midrun_out_valid",  bus.out_valid,  0);
      check("midrun_difference", bus.difference, 0);
      check("midrun_borrow_out", bus.borrow_out, 0);
      check("midrun_zero",       bus.zero,       0);
      @(negedge clk);
      #2 rst = 1'b0;
      run_txn("after_reset", 5, 2, 0, 3, 0, 0, 0, 1'b0);

      // Chain: feed each result back as the next minuend.
      xc = 200;
      for (int i = 0; i < 200; i++) begin
         r = ref_sub(xc, 1, 0);
         run_txn("chain", xc, 1, 0, r.d, r.bo, r.z, 0, 1'b0);
         xc = r.d;
      end
      check("chain_final_diff", bus.difference, 0);
      check("chain_final_zero", bus.zero,       1);
      check("chain_final_bo",   bus.borrow_out, 0);
      run_txn("chain_wrap", 0, 1, 0, SAT ? 0 : 255, 1, SAT ? 1 : 0, 0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         int x;
         int y;
         int b;
         x = int'($urandom_range(0, MOD - 1));
         y = int'($urandom_range(0, MOD - 1));
         b = int'($urandom_range(0, 1));
         r = ref_sub(x, y, b);
         run_txn("random", x, y, b, r.d, r.bo, r.z,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Free-running stream: consumer always ready, producer always valid.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.X        = W'($urandom);
         bus.Y        = W'($urandom);
         bus.B0       = 1'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (W + 3) @(negedge clk);
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("stream_drained", bus.in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
